trig_req_scheduler: RTL and testbench

//  Shares one sincos unit (single-precision sine/cosine, start/done handshake) among
//  NUM_REQ requesters. Round-robin picks one request, latches its operand, pulses the

---
 rtl/trig_req_scheduler_pkg.sv | 15 +
 rtl/trig_req_scheduler_if.sv | 31 +++
 rtl/trig_req_scheduler_rr_arbiter.sv | 29 ++
 rtl/trig_req_scheduler.sv | 130 +++++++++++++
 tb/tb_trig_req_scheduler.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trig_req_scheduler_pkg.sv
// rtl/trig_req_scheduler_pkg.sv - shared types and constants for the sincos request scheduler
package trig_pkg;

    localparam int FP32_W = 32;
    localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } trig_state_t;

endpackage

// File: rtl/trig_req_scheduler_if.sv
// rtl/trig_req_scheduler_if.sv - requester and sincos-unit signal bundle for the scheduler
interface trig_req_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import trig_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [FP32_W*NUM_REQ-1:0] req_opx;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [FP32_W-1:0]         rsp_sin;
    logic [FP32_W-1:0]         rsp_cos;
    logic                      rsp_err;
    logic                      unit_start;
    logic [FP32_W-1:0]         unit_opx;
    logic [FP32_W-1:0]         unit_sin;
    logic [FP32_W-1:0]         unit_cos;
    logic                      unit_done;
    logic                      busy;

    modport master (
        output req_valid, req_opx, unit_sin, unit_cos, unit_done,
        input  req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err, unit_start, unit_opx, busy
    );

    modport slave (
        input  req_valid, req_opx, unit_sin, unit_cos, unit_done,
        output req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err, unit_start, unit_opx, busy
    );

endinterface

// File: rtl/trig_req_scheduler_rr_arbiter.sv
// rtl/trig_req_scheduler_rr_arbiter.sv - combinational round-robin pick starting after ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] sel;

    // Walk from the farthest candidate back to ptr+1 so the nearest requester overwrites.
    always_comb begin
        grant = '0;
        idx   = '0;
        sel   = '0;
        for (int k = N; k >= 1; k--) begin
            sel = IW'((int'(ptr) + k) % N);
            if (req[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/trig_req_scheduler.sv
// rtl/trig_req_scheduler.sv - round-robin sharing of one sincos unit among NUM_REQ requesters
module trig_req_scheduler
    import trig_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    trig_req_scheduler_if.slave  bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    trig_state_t          state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        gidx;
    logic [TW-1:0]        timer;
    logic [NUM_REQ-1:0]   win_grant;
    logic [IW-1:0]        win_idx;
    logic [FP32_W-1:0]    res_sin, res_cos;
    logic                 res_err;

    logic [NUM_REQ-1:0]   req_ready_q, rsp_valid_q;
    logic [FP32_W-1:0]    rsp_sin_q, rsp_cos_q, unit_opx_q;
    logic                 rsp_err_q, unit_start_q, busy_q;

    logic                 timer_hit;
    logic [TW-1:0]        timer_next;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx)
    );

    // timer holds the number of wait cycles already completed, so this cycle is timer+1
    assign timer_hit  = (timer == TMO_LAST);
    assign timer_next = (timer == TMO_MAX) ? timer : timer + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= IW'(NUM_REQ - 1);
            gidx         <= '0;
            timer        <= '0;
            res_sin      <= FP32_ZERO;
            res_cos      <= FP32_ZERO;
            res_err      <= 1'b0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_sin_q    <= FP32_ZERO;
            rsp_cos_q    <= FP32_ZERO;
            rsp_err_q    <= 1'b0;
            unit_start_q <= 1'b0;
            unit_opx_q   <= FP32_ZERO;
            busy_q       <= 1'b0;
        end else begin
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            unit_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        gidx         <= win_idx;
                        unit_opx_q   <= bus.req_opx[int'(win_idx)*FP32_W +: FP32_W];
                        req_ready_q  <= win_grant;
                        unit_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    ptr   <= gidx;
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    timer <= timer_next;
                    if (timer_hit) begin
                        res_sin <= FP32_ZERO;
                        res_cos <= FP32_ZERO;
                        res_err <= 1'b1;
                        state   <= RESP;
                    end else if (!bus.unit_done) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    timer <= timer_next;
                    // a result arriving on the last allowed cycle still counts
                    if (bus.unit_done) begin
                        res_sin <= bus.unit_sin;
                        res_cos <= bus.unit_cos;
                        res_err <= 1'b0;
                        state   <= RESP;
                    end else if (timer_hit) begin
                        res_sin <= FP32_ZERO;
                        res_cos <= FP32_ZERO;
                        res_err <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= NUM_REQ'(1) << gidx;
                    rsp_sin_q   <= res_sin;
                    rsp_cos_q   <= res_cos;
                    rsp_err_q   <= res_err;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_sin    = rsp_sin_q;
    assign bus.rsp_cos    = rsp_cos_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.unit_start = unit_start_q;
    assign bus.unit_opx   = unit_opx_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_trig_req_scheduler.sv
// tb/tb_trig_req_scheduler.sv - self-checking bench for trig_req_scheduler
module tb_trig_req_scheduler;

    localparam int N = 4;
    localparam int T = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_opx;
    logic [31:0]     unit_sin, unit_cos;
    logic            unit_done;

    always #5 clk = ~clk;

    trig_req_scheduler_if #(.NUM_REQ(N)) bus ();

    assign bus.req_valid = req_valid;
    assign bus.req_opx   = req_opx;
    assign bus.unit_sin  = unit_sin;
    assign bus.unit_cos  = unit_cos;
    assign bus.unit_done = unit_done;

    trig_req_scheduler #(.NUM_REQ(N), .TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int          cyc;
    int          last;
    logic        m_idle;
    logic [31:0] m_op;
    int          exp_rsp_cyc, exp_w;
    logic [31:0] exp_sin, exp_cos;
    logic        exp_err;
    logic [31:0] hold_sin, hold_cos;
    logic        hold_err;
    int          grant_log[$];
    int          last_grant_cyc, last_rsp_cyc;
    logic [N-1:0] keep_mask, rereq_mask;

    // behavioural sincos unit: mode 0 normal, 1 never drops done, 2 drops and never returns
    int          u_mode, u_lat, u_state, u_left;
    bit          rand_lat;
    int          lat_lo, lat_hi;
    logic [31:0] u_op;

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int exp_b2b[3]   = '{2, 1, 2};

    function automatic logic [31:0] f_sin(logic [31:0] x);
        if (x == 32'h3FC9_0FDB) return 32'h3F80_0000;
        return {x[15:0], x[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] f_cos(logic [31:0] x);
        if (x == 32'h3FC9_0FDB) return 32'h0000_0000;
        return x ^ 32'hFFFF_0000;
    endfunction

    function automatic int winner(logic [N-1:0] p, int from);
        for (int k = 1; k <= N; k++) begin
            if (p[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; last = N - 1; m_idle = 1'b1; m_op = '0;
        exp_rsp_cyc = -1; exp_w = 0;
        hold_sin = '0; hold_cos = '0; hold_err = 1'b0;
        keep_mask = '0; rereq_mask = '0; req_valid = '0;
        u_state = 0; unit_done = 1'b1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready",  bus.req_ready,  0);
        chk("rst_rsp_valid",  bus.rsp_valid,  0);
        chk("rst_rsp_sin",    bus.rsp_sin,    0);
        chk("rst_rsp_cos",    bus.rsp_cos,    0);
        chk("rst_rsp_err",    bus.rsp_err,    0);
        chk("rst_unit_start", bus.unit_start, 0);
        chk("rst_unit_opx",   bus.unit_opx,   0);
        chk("rst_busy",       bus.busy,       0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // one clock: predict from pre-edge inputs, check post-edge outputs, then react as requesters/unit
    task automatic step();
        logic [N-1:0]    pend, exp_rdy, exp_rv;
        logic [32*N-1:0] opsnap;
        logic            idle_c;
        int              w;
        pend = req_valid; opsnap = req_opx; idle_c = m_idle;
        @(posedge clk);
        #1;
        cyc++;
        exp_rdy = '0; exp_rv = '0; w = -1;
        if (idle_c && pend != '0) begin
            w = winner(pend, last);
            exp_rdy[w] = 1'b1;
            last = w; exp_w = w; m_idle = 1'b0;
            m_op = opsnap[32*w +: 32];
            if (rand_lat) u_lat = $urandom_range(lat_hi, lat_lo);
            if (u_mode == 0 && u_lat + 1 <= T) begin
                exp_rsp_cyc = cyc + u_lat + 3; exp_err = 1'b0;
                exp_sin = f_sin(m_op); exp_cos = f_cos(m_op);
            end else begin
                exp_rsp_cyc = cyc + T + 2; exp_err = 1'b1;
                exp_sin = '0; exp_cos = '0;
            end
        end
        if (cyc == exp_rsp_cyc) begin
            exp_rv[exp_w] = 1'b1;
            hold_sin = exp_sin; hold_cos = exp_cos; hold_err = exp_err;
            m_idle = 1'b1; exp_rsp_cyc = -1;
        end
        chk("req_ready",  bus.req_ready,  exp_rdy);
        chk("unit_start", bus.unit_start, (w >= 0));
        chk("unit_opx",   bus.unit_opx,   m_op);
        chk("rsp_valid",  bus.rsp_valid,  exp_rv);
        chk("rsp_sin",    bus.rsp_sin,    hold_sin);
        chk("rsp_cos",    bus.rsp_cos,    hold_cos);
        chk("rsp_err",    bus.rsp_err,    hold_err);
        chk("busy",       bus.busy,       !m_idle);
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) begin
                grant_log.push_back(i);
                last_grant_cyc = cyc;
                if (keep_mask[i]) req_opx[32*i +: 32] = $urandom;
                else req_valid[i] = 1'b0;
            end
            if (bus.rsp_valid[i]) begin
                last_rsp_cyc = cyc;
                if (rereq_mask[i]) begin
                    req_valid[i] = 1'b1; rereq_mask[i] = 1'b0;
                end
            end
        end
        case (u_state)
            1: begin
                if (u_mode == 1) u_state = 0;
                else begin unit_done = 1'b0; u_left = u_lat; u_state = 2; end
            end
            2: begin
                if (u_mode == 0) begin
                    u_left--;
                    if (u_left <= 0) begin
                        unit_done = 1'b1; unit_sin = f_sin(u_op); unit_cos = f_cos(u_op);
                        u_state = 0;
                    end
                end
            end
            default: ;
        endcase
        if (bus.unit_start) begin
            u_op = bus.unit_opx; u_state = 1;
        end
    endtask

    task automatic drain(int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(m_idle && req_valid == '0 && rereq_mask == '0) && k < budget);
        chk("drain_budget", (m_idle && req_valid == '0), 1);
    endtask

    task automatic request(int i, logic [31:0] op);
        req_opx[32*i +: 32] = op;
        req_valid[i] = 1'b1;
    endtask

    initial begin
        int c0;
        req_valid = '0; req_opx = '0; unit_sin = '0; unit_cos = '0; unit_done = 1'b1;
        u_mode = 0; u_lat = 1; rand_lat = 0; lat_lo = 1; lat_hi = 1;
        last_grant_cyc = 0; last_rsp_cyc = 0;
        #2;
        do_reset();

        // pi/2 on requester 0, unit answers after a long busy period
        u_mode = 0; u_lat = 8;
        request(0, 32'h3FC9_0FDB);
        c0 = cyc;
        drain(60);
        chk("t1_grant_lat", last_grant_cyc - c0, 1);
        chk("t1_rsp_sin",   bus.rsp_sin, 32'h3F80_0000);
        chk("t1_rsp_cos",   bus.rsp_cos, 32'h0);
        chk("t1_rsp_err",   bus.rsp_err, 0);

        // all four requesting continuously with random unit latencies
        do_reset();
        grant_log.delete();
        rand_lat = 1; lat_lo = 1; lat_hi = T - 1;
        keep_mask = '1;
        for (int i = 0; i < N; i++) request(i, $urandom);
        for (int k = 0; k < 200 && grant_log.size() < 5; k++) step();
        keep_mask = '0;
        drain(200);
        for (int i = 0; i < 5; i++)
            chk("t2_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
        rand_lat = 0;

        // unit never drops done: timeout error, then normal service
        u_mode = 1;
        request(1, $urandom);
        drain(60);
        chk("t3_err",      bus.rsp_err, 1);
        chk("t3_sin_zero", bus.rsp_sin, 0);
        chk("t3_tmo_lat",  last_rsp_cyc - last_grant_cyc, T + 2);
        u_mode = 0; u_lat = 3;
        request(3, $urandom);
        drain(60);
        chk("t3_next_err", bus.rsp_err, 0);

        // unit drops done and never raises it
        u_mode = 2;
        request(0, $urandom);
        drain(60);
        chk("t4_err", bus.rsp_err, 1);
        u_mode = 0; u_state = 0; unit_done = 1'b1;
        // done returns on the very last allowed wait cycle, then one cycle too late
        u_lat = T - 1;
        request(2, 32'h1234_5678);
        drain(60);
        chk("t4_edge_err", bus.rsp_err, 0);
        chk("t4_edge_sin", bus.rsp_sin, f_sin(32'h1234_5678));
        u_lat = T;
        request(1, $urandom);
        drain(60);
        chk("t4_late_err", bus.rsp_err, 1);

        // reset while waiting on the unit
        grant_log.delete();
        u_lat = T - 1;
        for (int i = 0; i < N; i++) request(i, $urandom);
        for (int k = 0; k < 20 && grant_log.size() == 0; k++) step();
        repeat (3) step();
        do_reset();
        grant_log.delete();
        rand_lat = 1; lat_lo = 1; lat_hi = T + 1;
        for (int i = 0; i < N; i++) request(i, $urandom);
        drain(300);
        chk("t5_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        rand_lat = 0;

        // minimum latency and back-to-back re-request
        u_lat = 1;
        request(3, $urandom);
        c0 = cyc;
        drain(40);
        chk("t6_min_lat", last_rsp_cyc - c0, 5);
        grant_log.delete();
        u_lat = 4;
        request(2, $urandom);
        for (int k = 0; k < 20 && grant_log.size() == 0; k++) step();
        request(1, $urandom);
        rereq_mask[2] = 1'b1;
        drain(100);
        for (int i = 0; i < 3; i++)
            chk("t6_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_b2b[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
